// File: rtl/roulette_pkg.sv
// Shared definitions for the roulette game: state codes, random-number width,
// LFSR taps and the next-state function of the 16-bit Fibonacci LFSR.
package roulette_pkg;

   localparam logic [1:0] IDLE      = 2'b00;
   localparam logic [1:0] SPIN_FAST = 2'b01;
   localparam logic [1:0] SPIN_SLOW = 2'b10;
   localparam logic [1:0] HOLD      = 2'b11;

   localparam int RAND_W       = 5;
   localparam int BALANCE_INIT = 10;

   // Taps for x^16 + x^14 + x^13 + x^11 + 1
   localparam int LFSR_TAP_A = 15;
   localparam int LFSR_TAP_B = 13;
   localparam int LFSR_TAP_C = 12;
   localparam int LFSR_TAP_D = 10;

   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
   endfunction

endpackage

// File: rtl/roulette_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, held at its seed while reset_n is low.
// Usable by any game mode that needs a pseudo-random source.
module roulette_lfsr16
   import roulette_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   output logic [15:0] o_state
);

   logic [15:0] r_state;

   // LFSR state register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= SEED;
      end else begin
         r_state <= lfsr16_next(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/roulette_wheel_spinner.sv
// Spins a decelerating wheel on a spin request edge, then presents the landing
// slot on o_randnum with o_result_valid until the game acknowledges it.
module roulette_wheel_spinner
   import roulette_pkg::*;
#(
   parameter int          SLOTS      = 32,
   parameter int          TICK_BASE  = 4,
   parameter int          MIN_STEPS  = 16,
   parameter int          SLOW_STEPS = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_spin_req,
   input  logic              i_result_ack,
   output logic [RAND_W-1:0] o_randnum,
   output logic              o_result_valid,
   output logic              o_spinning,
   output logic [RAND_W-1:0] o_wheel_pos
);

   localparam int TICK_W = $clog2(TICK_BASE * (SLOW_STEPS + 1) + 1);
   localparam int K_W    = $clog2(SLOW_STEPS + 2);

   logic [1:0]        r_state;
   logic [5:0]        r_steps_left;
   logic [TICK_W-1:0] r_tick;
   logic [K_W-1:0]    r_slow_k;
   logic [RAND_W-1:0] r_wheel_pos;
   logic [RAND_W-1:0] r_randnum;
   logic              r_result_valid;
   logic              r_spinning;
   logic              r_spin_req_q;

   logic [15:0]       w_lfsr;
   logic              w_unused_lfsr;
   logic              w_start;
   logic [5:0]        w_load;
   logic [31:0]       w_period;
   logic              w_step;
   logic [RAND_W-1:0] w_pos_inc;

   logic [1:0]        w_state_nxt;
   logic [5:0]        w_steps_nxt;
   logic [TICK_W-1:0] w_tick_nxt;
   logic [K_W-1:0]    w_slow_k_nxt;
   logic [RAND_W-1:0] w_pos_nxt;
   logic [RAND_W-1:0] w_rand_nxt;
   logic              w_valid_nxt;

   roulette_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .o_state   (w_lfsr)
   );

   assign w_unused_lfsr = ^w_lfsr[15:4];
   assign w_start       = i_spin_req & ~r_spin_req_q;
   assign w_load        = 6'(MIN_STEPS) + {2'b00, w_lfsr[3:0]};
   assign w_pos_inc     = (r_wheel_pos == RAND_W'(SLOTS - 1)) ? {RAND_W{1'b0}} : r_wheel_pos + 1'b1;
   assign w_step        = (32'(r_tick) == w_period - 32'd1);

   // Step period: constant in the fast phase, stretching by TICK_BASE per slow step
   always_comb begin
      w_period = 32'(TICK_BASE);
      if (r_state == SPIN_SLOW) begin
         w_period = 32'(TICK_BASE) * (32'(r_slow_k) + 32'd1);
      end else begin
         w_period = 32'(TICK_BASE);
      end
   end

   // Next-state and datapath decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_steps_nxt  = r_steps_left;
      w_tick_nxt   = r_tick;
      w_slow_k_nxt = r_slow_k;
      w_pos_nxt    = r_wheel_pos;
      w_rand_nxt   = r_randnum;
      w_valid_nxt  = r_result_valid;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_steps_nxt  = w_load;
               w_tick_nxt   = {TICK_W{1'b0}};
               w_slow_k_nxt = K_W'(1);
               w_state_nxt  = (w_load <= 6'(SLOW_STEPS)) ? SPIN_SLOW : SPIN_FAST;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SPIN_FAST, SPIN_SLOW: begin
            if (w_step) begin
               w_pos_nxt   = w_pos_inc;
               w_steps_nxt = r_steps_left - 6'd1;
               w_tick_nxt  = {TICK_W{1'b0}};
               if (r_state == SPIN_SLOW) begin
                  w_slow_k_nxt = r_slow_k + 1'b1;
                  if (r_steps_left == 6'd1) begin
                     w_state_nxt = HOLD;
                     w_rand_nxt  = w_pos_inc;
                     w_valid_nxt = 1'b1;
                  end else begin
                     w_state_nxt = SPIN_SLOW;
                  end
               end else if (r_steps_left == 6'(SLOW_STEPS + 1)) begin
                  w_state_nxt = SPIN_SLOW;
               end else begin
                  w_state_nxt = SPIN_FAST;
               end
            end else begin
               w_tick_nxt = r_tick + 1'b1;
            end
         end
         HOLD: begin
            // A start edge coinciding with the ack is dropped, not queued
            if (i_result_ack) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state        <= IDLE;
         r_steps_left   <= 6'd0;
         r_tick         <= {TICK_W{1'b0}};
         r_slow_k       <= {K_W{1'b0}};
         r_wheel_pos    <= {RAND_W{1'b0}};
         r_randnum      <= {RAND_W{1'b0}};
         r_result_valid <= 1'b0;
         r_spinning     <= 1'b0;
         r_spin_req_q   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_steps_left   <= w_steps_nxt;
         r_tick         <= w_tick_nxt;
         r_slow_k       <= w_slow_k_nxt;
         r_wheel_pos    <= w_pos_nxt;
         r_randnum      <= w_rand_nxt;
         r_result_valid <= w_valid_nxt;
         r_spinning     <= (w_state_nxt == SPIN_FAST) || (w_state_nxt == SPIN_SLOW);
         r_spin_req_q   <= i_spin_req;
      end
   end

   assign o_randnum      = r_randnum;
   assign o_result_valid = r_result_valid;
   assign o_spinning     = r_spinning;
   assign o_wheel_pos    = r_wheel_pos;

endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Directed bench for roulette_wheel_spinner at default parameters, with its own
// LFSR reference used to predict each spin's step count and landing slot.
module tb_roulette_wheel_spinner;

   logic       clk;
   logic       reset_n;
   logic       spin_req;
   logic       result_ack;
   logic [4:0] randnum;
   logic       result_valid;
   logic       spinning;
   logic [4:0] wheel_pos;

   int total = 0;
   int bad   = 0;
   int gaps[$];
   int wraps;
   logic [15:0] m_lfsr;

   roulette_wheel_spinner dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_spin_req     (spin_req),
      .i_result_ack   (result_ack),
      .o_randnum      (randnum),
      .o_result_valid (result_valid),
      .o_spinning     (spinning),
      .o_wheel_pos    (wheel_pos)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] ref_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Reference LFSR: at each negedge it holds the value the DUT uses at the next edge
   always @(posedge clk) begin
      m_lfsr <= reset_n ? ref_next(m_lfsr) : 16'hACE1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Raise spin_req, follow the spin until spinning drops, check length/steps/result
   task automatic run_spin(input int start_pos, input bit toggle, output int n);
      int cycles;
      int last;
      int prev;
      gaps.delete();
      wraps    = 0;
      spin_req = 1'b1;
      n        = 16 + int'(m_lfsr[3:0]);
      cycles   = 0;
      last     = 1;
      prev     = start_pos;
      do begin
         @(negedge clk);
         cycles++;
         if (toggle && (cycles % 5 == 0)) spin_req = ~spin_req;
         if (int'(wheel_pos) != prev) begin
            if (prev == 31 && wheel_pos == 5'd0) wraps++;
            gaps.push_back(cycles - last);
            last = cycles;
            prev = int'(wheel_pos);
         end
      end while (spinning && cycles < 600);
      spin_req = 1'b0;
      chk("spin_cycles", cycles - 1, (n - 4) * 4 + 56);
      chk("step_count", gaps.size(), n);
      chk("result", int'(randnum), (start_pos + n) % 32);
      chk("valid_set", int'(result_valid), 1);
   endtask

   initial begin
      int n;
      int hb;
      int w;
      int exp_r;
      reset_n    = 1'b0;
      spin_req   = 1'b1;
      result_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_randnum", int'(randnum), 0);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_spinning", int'(spinning), 0);
      chk("rst_pos", int'(wheel_pos), 0);

      // Basic spin: seed nibble 1 gives 17 steps
      reset_n = 1'b1;
      run_spin(0, 1'b0, n);
      chk("basic_randnum", int'(randnum), 17);
      if (gaps.size() >= 17) begin
         chk("gap_first", gaps[0], 4);
         chk("gap_fast_last", gaps[12], 4);
         chk("gap_slow1", gaps[13], 8);
         chk("gap_slow2", gaps[14], 12);
         chk("gap_slow3", gaps[15], 16);
         chk("gap_slow4", gaps[16], 20);
      end else begin
         chk("gap_list", gaps.size(), 17);
      end

      hb = 0;
      repeat (50) begin
         @(negedge clk);
         if (randnum !== 5'd17 || result_valid !== 1'b1 || spinning !== 1'b0) hb++;
      end
      chk("hold_stable", hb, 0);

      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk("ack_clear", int'(result_valid), 0);
      chk("pos_kept", int'(wheel_pos), 17);
      @(negedge clk);
      chk("idle_no_spin", int'(spinning), 0);

      // Wrap-around: wait for nibble 15 so N=31 from slot 17
      w = 0;
      while (m_lfsr[3:0] != 4'hF && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("find_nibble", int'(m_lfsr[3:0]), 15);
      run_spin(17, 1'b0, n);
      chk("wrap_result", int'(randnum), 16);
      chk("wrap_once", wraps, 1);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      @(negedge clk);

      // Requests toggled during the spin and in HOLD are ignored
      run_spin(16, 1'b1, n);
      exp_r = (16 + n) % 32;
      hb = 0;
      repeat (12) begin
         spin_req = ~spin_req;
         @(negedge clk);
         if (result_valid !== 1'b1 || spinning !== 1'b0 || int'(randnum) != exp_r) hb++;
      end
      chk("hold_ignore", hb, 0);
      spin_req = 1'b0;
      @(negedge clk);
      result_ack = 1'b1;
      spin_req   = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk("ack_edge_valid", int'(result_valid), 0);
      hb = 0;
      repeat (10) begin
         @(negedge clk);
         if (spinning !== 1'b0) hb++;
      end
      chk("ack_edge_no_spin", hb, 0);
      spin_req = 1'b0;
      @(negedge clk);

      // Reset during the slow phase
      spin_req = 1'b1;
      n = 16 + int'(m_lfsr[3:0]);
      repeat ((n - 4) * 4 + 10) @(negedge clk);
      chk("mid_spinning", int'(spinning), 1);
      reset_n  = 1'b0;
      spin_req = 1'b0;
      @(negedge clk);
      chk("mid_rst_spinning", int'(spinning), 0);
      chk("mid_rst_pos", int'(wheel_pos), 0);
      chk("mid_rst_randnum", int'(randnum), 0);
      chk("mid_rst_valid", int'(result_valid), 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_spin(0, 1'b0, n);
      chk("reseed_result", int'(randnum), 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
